// File: rtl/fp_execute_stage5_pkg.sv
// Shared types and constants for the final floating-point execute stage.
//   decoded_instruction_t : decoded instruction; alu_op selects the result path
//   vector_lane_mask_t    : per-lane enable mask
//   thread_idx_t          : issuing thread index
//   subcycle_t            : subcycle index of a multi-cycle vector op
package fp_execute_stage5_pkg;

    localparam int VECTOR_LANES      = 16;
    localparam int FLOAT32_EXP_WIDTH = 8;
    localparam int FLOAT32_SIG_WIDTH = 23;

    localparam logic [31:0] QNAN = 32'h7FFFFFFF;

    typedef logic [5:0] alu_op_t;

    localparam alu_op_t OP_FADD = 6'h20;
    localparam alu_op_t OP_FSUB = 6'h21;
    localparam alu_op_t OP_FMUL = 6'h22;
    localparam alu_op_t OP_FTOI = 6'h23;

    typedef struct packed {
        logic       has_dest;
        logic [4:0] dest_reg;
        alu_op_t    alu_op;
    } decoded_instruction_t;

    typedef logic [VECTOR_LANES-1:0] vector_lane_mask_t;
    typedef logic [1:0]              thread_idx_t;
    typedef logic [3:0]              subcycle_t;

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even and IEEE-754 single packing for one lane.
//   i_sign      : result sign
//   i_exponent  : biased exponent, 10-bit two's complement (may be <= 0 or >= 255)
//   i_mantissa  : 23-bit fraction before rounding
//   i_guard     : first bit below the fraction
//   i_sticky    : OR of all remaining lower bits
//   i_is_inf    : force signed infinity
//   i_is_nan    : force quiet NaN (wins over i_is_inf)
//   o_result    : packed 32-bit float
module fp_round_pack
    import fp_execute_stage5_pkg::*;
(
    input  logic                         i_sign,
    input  logic [9:0]                   i_exponent,
    input  logic [FLOAT32_SIG_WIDTH-1:0] i_mantissa,
    input  logic                         i_guard,
    input  logic                         i_sticky,
    input  logic                         i_is_inf,
    input  logic                         i_is_nan,
    output logic [31:0]                  o_result
);

    logic                         w_round_up;
    logic [FLOAT32_SIG_WIDTH:0]   w_rounded;
    logic signed [9:0]            w_exp;

    // Ties go up only when the fraction is odd, giving ties-to-even.
    assign w_round_up = i_guard & (i_sticky | i_mantissa[0]);
    assign w_rounded  = {1'b0, i_mantissa} + {{FLOAT32_SIG_WIDTH{1'b0}}, w_round_up};
    // A carry out of the fraction leaves the low 23 bits at zero already.
    assign w_exp      = $signed(i_exponent + {9'b0, w_rounded[FLOAT32_SIG_WIDTH]});

    always_comb begin
        o_result = {i_sign, w_exp[FLOAT32_EXP_WIDTH-1:0], w_rounded[FLOAT32_SIG_WIDTH-1:0]};
        if (i_is_nan) begin
            o_result = QNAN;
        end else if (i_is_inf) begin
            o_result = {i_sign, {FLOAT32_EXP_WIDTH{1'b1}}, {FLOAT32_SIG_WIDTH{1'b0}}};
        end else if (w_exp <= 10'sd0) begin
            // No denormal support: flush to signed zero.
            o_result = {i_sign, 31'b0};
        end else if (w_exp >= 10'sd255) begin
            o_result = {i_sign, {FLOAT32_EXP_WIDTH{1'b1}}, {FLOAT32_SIG_WIDTH{1'b0}}};
        end
    end

endmodule

// File: rtl/fp_execute_stage5.sv
// Final floating-point pipeline stage: normalizes, rounds and packs per-lane
// results of the add/sub, multiply and float-to-int paths, then registers the
// result and control toward writeback. Fixed 1-cycle latency, no backpressure.
//   clk, reset                 : clock, asynchronous active-high reset
//   fx4_*                      : stage-4 instruction, control and per-lane operands
//   fx5_instruction_valid ...  : registered control, passed through
//   fx5_result                 : registered per-lane packed results (not reset)
module fp_execute_stage5
    import fp_execute_stage5_pkg::*;
#(
    parameter int NUM_LANES = VECTOR_LANES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fx4_instruction_valid,
    input  decoded_instruction_t  fx4_instruction,
    input  vector_lane_mask_t     fx4_mask_value,
    input  thread_idx_t           fx4_thread_idx,
    input  subcycle_t             fx4_subcycle,
    input  logic [NUM_LANES-1:0]  fx4_result_is_inf,
    input  logic [NUM_LANES-1:0]  fx4_result_is_nan,
    input  logic [31:0]           fx4_add_significand [NUM_LANES],
    input  logic [7:0]            fx4_add_exponent [NUM_LANES],
    input  logic [NUM_LANES-1:0]  fx4_add_result_sign,
    input  logic [NUM_LANES-1:0]  fx4_logical_subtract,
    input  logic [5:0]            fx4_norm_shift [NUM_LANES],
    input  logic [63:0]           fx4_significand_product [NUM_LANES],
    input  logic [7:0]            fx4_mul_exponent [NUM_LANES],
    input  logic [NUM_LANES-1:0]  fx4_mul_sign,
    output logic                  fx5_instruction_valid,
    output decoded_instruction_t  fx5_instruction,
    output vector_lane_mask_t     fx5_mask_value,
    output thread_idx_t           fx5_thread_idx,
    output subcycle_t             fx5_subcycle,
    output logic [31:0]           fx5_result [NUM_LANES]
);

    logic                 r_valid;
    decoded_instruction_t r_instruction;
    vector_lane_mask_t    r_mask_value;
    thread_idx_t          r_thread_idx;
    subcycle_t            r_subcycle;
    logic [31:0]          r_result [NUM_LANES];

    logic w_is_fmul;
    logic w_is_ftoi;

    assign w_is_fmul = (fx4_instruction.alu_op == OP_FMUL);
    assign w_is_ftoi = (fx4_instruction.alu_op == OP_FTOI);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [31:0] w_shifted;
        logic        w_add_zero;
        logic [9:0]  w_add_exp;
        logic [9:0]  w_mul_exp;
        logic        w_mul_hi;
        logic        w_sign;
        logic [9:0]  w_exp;
        logic [22:0] w_mant;
        logic        w_guard;
        logic        w_sticky;
        logic [31:0] w_packed;
        logic [31:0] w_ftoi;
        logic [31:0] w_lane_result;
        logic        w_unused_prod_hi;

        // Shifts of 32 or more clear the value, which covers the exact-cancel case.
        assign w_shifted  = fx4_add_significand[g] << fx4_norm_shift[g];
        assign w_add_zero = (fx4_add_significand[g] == 32'd0);
        // Forcing the exponent to zero makes the packer emit a signed zero.
        assign w_add_exp  = w_add_zero ? 10'd0
                          : 10'(fx4_add_exponent[g]) + 10'd1 - 10'(fx4_norm_shift[g]);

        assign w_mul_hi         = fx4_significand_product[g][47];
        assign w_mul_exp        = 10'(fx4_mul_exponent[g]) + {9'b0, w_mul_hi};
        assign w_unused_prod_hi = ^fx4_significand_product[g][63:48];

        always_comb begin
            // Exact cancellation yields +0; an explicit infinity keeps its sign.
            w_sign   = fx4_add_result_sign[g]
                     & ~(w_add_zero & fx4_logical_subtract[g] & ~fx4_result_is_inf[g]);
            w_exp    = w_add_exp;
            w_mant   = w_shifted[30:8];
            w_guard  = w_shifted[7];
            w_sticky = |w_shifted[6:0];
            if (w_is_fmul) begin
                w_sign = fx4_mul_sign[g];
                w_exp  = w_mul_exp;
                if (w_mul_hi) begin
                    w_mant   = fx4_significand_product[g][46:24];
                    w_guard  = fx4_significand_product[g][23];
                    w_sticky = |fx4_significand_product[g][22:0];
                end else begin
                    w_mant   = fx4_significand_product[g][45:23];
                    w_guard  = fx4_significand_product[g][22];
                    w_sticky = |fx4_significand_product[g][21:0];
                end
            end
        end

        fp_round_pack u_round_pack (
            .i_sign     (w_sign),
            .i_exponent (w_exp),
            .i_mantissa (w_mant),
            .i_guard    (w_guard),
            .i_sticky   (w_sticky),
            .i_is_inf   (fx4_result_is_inf[g]),
            .i_is_nan   (fx4_result_is_nan[g]),
            .o_result   (w_packed)
        );

        assign w_ftoi        = fx4_add_result_sign[g] ? (~w_shifted + 32'd1) : w_shifted;
        // Float-to-int honours NaN but not infinity.
        assign w_lane_result = w_is_ftoi ? (fx4_result_is_nan[g] ? QNAN : w_ftoi) : w_packed;

        always_ff @(posedge clk) begin
            r_result[g] <= w_lane_result;
        end

        assign fx5_result[g] = r_result[g];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_instruction <= '0;
            r_mask_value  <= '0;
            r_thread_idx  <= '0;
            r_subcycle    <= '0;
        end else begin
            r_valid       <= fx4_instruction_valid;
            r_instruction <= fx4_instruction;
            r_mask_value  <= fx4_mask_value;
            r_thread_idx  <= fx4_thread_idx;
            r_subcycle    <= fx4_subcycle;
        end
    end

    assign fx5_instruction_valid = r_valid;
    assign fx5_instruction       = r_instruction;
    assign fx5_mask_value        = r_mask_value;
    assign fx5_thread_idx        = r_thread_idx;
    assign fx5_subcycle          = r_subcycle;

endmodule

// File: doc/fp_execute_stage5.md
Name: fp_execute_stage5

Overview:
- Final floating-point pipeline stage. It is the consumer of the stage-4 fx4_* interface.
- Applies the normalization shift computed upstream, rounds to nearest-even and packs IEEE-754 single results.
- Selects the add/sub, multiply or float-to-int path per lane.
- Registers the result and control toward writeback with fixed 1-cycle latency.

Parameters:
- NUM_LANES, default `VECTOR_LANES (16): number of vector lanes processed in parallel.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- fx4_instruction_valid  input  1  stage-4 instruction valid
- fx4_instruction  input  decoded_instruction_t  decoded instruction; alu_op selects the path
- fx4_mask_value  input  vector_lane_mask_t  lane enable mask
- fx4_thread_idx  input  thread_idx_t  issuing thread
- fx4_subcycle  input  subcycle_t  subcycle index
- fx4_result_is_inf  input  NUM_LANES  force infinity per lane
- fx4_result_is_nan  input  NUM_LANES  force NaN per lane
- fx4_add_significand  input  NUM_LANES x 32  unnormalized add/sub significand
- fx4_add_exponent  input  NUM_LANES x 8  add/sub pre-normalization exponent
- fx4_add_result_sign  input  NUM_LANES  add/sub result sign
- fx4_logical_subtract  input  NUM_LANES  operation was an effective subtract
- fx4_norm_shift  input  NUM_LANES x 6  leading-zero count; for FTOI, the left shift amount
- fx4_significand_product  input  NUM_LANES x 64  24x24 significand product in bits 47:0
- fx4_mul_exponent  input  NUM_LANES x 8  multiply unbiased-sum exponent (rebiased)
- fx4_mul_sign  input  NUM_LANES  multiply sign
- fx5_instruction_valid  output  1  result valid
- fx5_instruction  output  decoded_instruction_t  passed through
- fx5_mask_value  output  vector_lane_mask_t  passed through
- fx5_thread_idx  output  thread_idx_t  passed through
- fx5_subcycle  output  subcycle_t  passed through
- fx5_result  output  NUM_LANES x 32  packed per-lane results

Behaviour:
- Latency is exactly 1 cycle, with no stall or backpressure. Every input cycle produces one output cycle.
- Reset (asynchronous, active-high) clears fx5_instruction_valid, fx5_instruction, fx5_mask_value, fx5_thread_idx and fx5_subcycle to 0.
- fx5_result is not reset and is don't-care while valid is 0.
- Reset asserted mid-stream drops the in-flight instruction: valid reads 0 on the next edge. Operation resumes on the first clock after deassert.
- Add path, for any alu_op other than OP_FMUL and OP_FTOI:
  - shifted = significand << norm_shift (32 bits)
  - mantissa = shifted[30:8]; guard = shifted[7]; sticky = |shifted[6:0]
  - round up when guard & (sticky | mantissa[0])
  - exponent = add_exponent + 1 - norm_shift, computed in a 10-bit signed intermediate
  - a rounding carry out of the mantissa increments the exponent and zeroes the mantissa
- Add-path special cases:
  - significand == 0 (norm_shift 32): result is +0 when logical_subtract, otherwise {sign, 31'b0}.
  - final exponent <= 0: flush to signed zero (no denormals).
  - final exponent >= 255: signed infinity.
- Multiply path (OP_FMUL):
  - product[47] = 1: mantissa = product[46:24], guard = product[23], sticky = |product[22:0], exponent = mul_exponent + 1.
  - otherwise: mantissa = product[45:23], guard = product[22], sticky = |product[21:0], exponent = mul_exponent.
  - same round-to-nearest-even, carry, underflow and overflow rules as the add path; sign = mul_sign.
- FTOI path (OP_FTOI):
  - value = add_significand << norm_shift, truncated to 32 bits.
  - result is the two's complement negation of value when add_result_sign = 1.
  - FTOI ignores is_inf.
- Overrides: is_nan takes priority and yields 32'h7FFFFFFF. Otherwise is_inf yields {sign, 8'hFF, 23'b0}, where sign comes from the selected path.
- Masked-off lanes still compute; the consumer applies fx5_mask_value.

Decomposition:
- Shared package: decoded_instruction_t, alu_op encodings (OP_FMUL, OP_FTOI), FLOAT32_EXP_WIDTH = 8, FLOAT32_SIG_WIDTH = 23, QNAN constant 32'h7FFFFFFF.
- One combinational sub-module per lane: fp_round_pack. Inputs are sign, 10-bit exponent, 23-bit mantissa, guard, sticky, is_inf and is_nan; output is the packed 32-bit word. The top level instantiates it in a generate loop and owns all flops.

Test Plan:
- Add 1.0+1.0: significand 32'h80000000, exp 127, shift 0 -> fx5_result 32'h40000000, valid one cycle after input.
- Tie rounding: significand 32'h400000C0, shift 1, exp 127 -> 32'h3F800002. Significand 32'h40000040, shift 1 -> 32'h3F800000 (ties to even).
- Exact cancel: significand 0, shift 32, logical_subtract 1, sign 1 -> 32'h00000000. Exp 254, significand 32'h80000000, shift 0 -> 32'h7F800000.
- FMUL 1.5*1.5: product 64'h0000_9000_0000_0000, mul_exponent 127 -> 32'h40100000. Same with is_nan=1 -> 32'h7FFFFFFF.
- FTOI: significand 32'h00000005, shift 0, sign 1 -> 32'hFFFFFFFB. is_inf=1 does not alter it.
- Back-to-back valid instructions on 3 consecutive cycles, differing thread_idx and subcycle -> outputs in order with matching control. Reset asserted in cycle 2 -> valid=0 asynchronously; the first input after release emerges one cycle later.
